btn_conditioner: RTL and testbench

Conditions one raw asynchronous push-button or switch input into clean synchronous signals.
- Path: SYNC_STAGES-flop synchronizer, then a debounce FSM.
- Outputs: debounced level, single-cycle rise/fall pulses, and a one-shot long-press pulse.
- Sits directly upstream of the lab flip-flop, counter and register blocks; their D, enable or reset inputs are driven from level, rise or hold.

---
 rtl/btn_conditioner.sv | 160 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// btn_conditioner : raw button -> synchronizer -> debounce FSM (level/rise/fall/hold)
// Rev 1.0
// ============================================================================
module btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold,
  output logic busy
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    ARM_HIGH = 2'd1,
    HIGH     = 2'd2,
    ARM_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_TARGET  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_TARGET = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               DIRECT_ARM  = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   s;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] dcnt_next;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_next;
  logic [CNT_W-1:0] hcnt_inc;
  logic             hold_armed;
  logic             rise_next;
  logic             fall_next;
  logic             hold_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign s = sync_chain[SYNC_STAGES-1];

  // Hold counter saturates at its target, so the pulse can fire only once per press.
  assign hcnt_inc   = hcnt + CNT_ONE;
  assign hold_armed = (hcnt != HOLD_TARGET);

  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    hcnt_next  = hcnt;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    hold_next  = 1'b0;

    case (state)
      LOW: begin
        if (s) begin
          if (DIRECT_ARM) begin
            state_next = HIGH;
            rise_next  = 1'b1;
            hcnt_next  = '0;
            dcnt_next  = '0;
          end else begin
            state_next = ARM_HIGH;
            dcnt_next  = CNT_ONE;
          end
        end
      end

      ARM_HIGH: begin
        if (!s) begin
          state_next = LOW;
          dcnt_next  = '0;
        end else if (dcnt == DEB_TARGET) begin
          state_next = HIGH;
          rise_next  = 1'b1;
          hcnt_next  = '0;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt + CNT_ONE;
        end
      end

      HIGH: begin
        if (!s) begin
          state_next = ARM_LOW;
          dcnt_next  = CNT_ONE;
        end else if (hold_armed) begin
          hcnt_next = hcnt_inc;
          hold_next = (hcnt_inc == HOLD_TARGET);
        end
      end

      ARM_LOW: begin
        if (s) begin
          // A short dip resumes the press; the hold count keeps its progress.
          state_next = HIGH;
          dcnt_next  = '0;
          if (hold_armed) begin
            hcnt_next = hcnt_inc;
            hold_next = (hcnt_inc == HOLD_TARGET);
          end
        end else if (dcnt == DEB_TARGET) begin
          state_next = LOW;
          fall_next  = 1'b1;
          hcnt_next  = '0;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt + CNT_ONE;
        end
      end

      default: begin
        state_next = LOW;
        dcnt_next  = '0;
        hcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      dcnt  <= '0;
      hcnt  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      hold  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
      hcnt  <= hcnt_next;
      level <= (state_next == HIGH) || (state_next == ARM_LOW);
      busy  <= (state_next == ARM_HIGH) || (state_next == ARM_LOW);
      rise  <= rise_next;
      fall  <= fall_next;
      hold  <= hold_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// Bench for btn_conditioner: vector table, directed corner sequences and
// random stimulus against a run-length reference model.
module tb_btn_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int HOLDC = 16;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic btn_f;
  logic level, rise, fall, hold, busy;
  logic level_f, rise_f, fall_f, hold_f, busy_f;
  logic [4:0] dut_vec;

  assign dut_vec = {level, rise, fall, hold, busy};

  int n_cmp      = 0;
  int n_bad      = 0;
  int fast_holds = 0;

  // Reference model: delay line for the synchronizer, then a run-length rule:
  // DEB+1 consecutive samples disagreeing with the level flip it.
  logic [SYNC-1:0] m_pipe;
  int              m_run;
  int              m_hcnt;
  logic            m_lvl, m_rise, m_fall, m_hold;

  typedef struct {
    logic       r;
    logic       b;
    logic [4:0] exp;
  } vec_t;

  vec_t tv[$];

  always #5 clk = ~clk;

  btn_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLDC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn),
    .level(level), .rise(rise), .fall(fall), .hold(hold), .busy(busy)
  );

  btn_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(0), .CNT_W(8)
  ) dut_fast (
    .clk(clk), .rst(rst), .btn_raw(btn_f),
    .level(level_f), .rise(rise_f), .fall(fall_f), .hold(hold_f), .busy(busy_f)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic b);
    logic sv;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_hold = 1'b0;
    if (r) begin
      m_pipe = '0;
      m_run  = 0;
      m_hcnt = 0;
      m_lvl  = 1'b0;
      return;
    end
    sv     = m_pipe[SYNC-1];
    m_pipe = {m_pipe[SYNC-2:0], b};
    if (m_lvl && sv && (m_hcnt < HOLDC)) begin
      m_hcnt++;
      m_hold = (m_hcnt == HOLDC);
    end
    m_run = (sv != m_lvl) ? m_run + 1 : 0;
    if (m_run > DEB) begin
      m_lvl  = ~m_lvl;
      m_run  = 0;
      m_hcnt = 0;
      m_rise = m_lvl;
      m_fall = ~m_lvl;
    end
  endtask

  function automatic logic [4:0] model_vec();
    return {m_lvl, m_rise, m_fall, m_hold, (m_run != 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(rst, btn);
    #1;
    if (hold_f) fast_holds++;
    check("model", int'(dut_vec), int'(model_vec()));
  endtask

  initial begin
    int nr, nh, nf, r_at, h_at, early, busy_seen, low_seen;
    rst   = 1'b1;
    btn   = 1'b0;
    btn_f = 1'b0;
    model_edge(1'b1, 1'b0);

    // {rst, btn_raw, expected {level,rise,fall,hold,busy}}
    tv.push_back('{1'b1, 1'b0, 5'b00000}); tv.push_back('{1'b1, 1'b0, 5'b00000});
    tv.push_back('{1'b1, 1'b0, 5'b00000});
    tv.push_back('{1'b0, 1'b1, 5'b00000}); tv.push_back('{1'b0, 1'b1, 5'b00000});
    tv.push_back('{1'b0, 1'b1, 5'b00001}); tv.push_back('{1'b0, 1'b1, 5'b00001});
    tv.push_back('{1'b0, 1'b1, 5'b00001}); tv.push_back('{1'b0, 1'b1, 5'b00001});
    tv.push_back('{1'b0, 1'b1, 5'b11000}); tv.push_back('{1'b0, 1'b1, 5'b10000});
    tv.push_back('{1'b0, 1'b0, 5'b10000}); tv.push_back('{1'b0, 1'b0, 5'b10000});
    tv.push_back('{1'b0, 1'b0, 5'b10001}); tv.push_back('{1'b0, 1'b0, 5'b10001});
    tv.push_back('{1'b0, 1'b0, 5'b10001}); tv.push_back('{1'b0, 1'b0, 5'b10001});
    tv.push_back('{1'b0, 1'b0, 5'b00100}); tv.push_back('{1'b0, 1'b0, 5'b00000});

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].r;
      btn = tv[i].b;
      step();
      check("table", int'(dut_vec), int'(tv[i].exp));
      if (i == 2) check("fast_reset", int'({level_f, rise_f, fall_f, hold_f, busy_f}), 0);
    end

    // Long press: rise at edge 6, hold 16 cycles later, one of each.
    btn = 1'b1; nr = 0; nh = 0; r_at = -1; h_at = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rise) begin nr++; r_at = k; end
      if (hold) begin nh++; h_at = k; end
    end
    check("press_rise_edge", r_at, 6);
    check("press_hold_edge", h_at, 22);
    check("press_rise_count", nr, 1);
    check("press_hold_count", nh, 1);
    btn = 1'b0;
    repeat (12) step();
    check("press_release_level", int'(level), 0);

    // Bounce 1,0,1,1,0,1 then stable 1.
    nr = 0; nh = 0; r_at = -1; early = 0; busy_seen = 0;
    for (int k = 0; k < 32; k++) begin
      btn = (k == 1 || k == 4) ? 1'b0 : 1'b1;
      step();
      if (k < 11 && (rise || fall || hold || level)) early++;
      if (k < 11 && busy) busy_seen++;
      if (rise) begin nr++; r_at = k; end
      if (hold) nh++;
    end
    check("bounce_no_early_pulse", early, 0);
    check("bounce_busy_seen", int'(busy_seen > 0), 1);
    check("bounce_rise_edge", r_at, 11);
    check("bounce_rise_count", nr, 1);
    check("bounce_hold_count", nh, 1);

    // Short dip while high (hold already fired), then a real release.
    nf = 0; nh = 0; low_seen = 0;
    for (int k = 0; k < 13; k++) begin
      btn = (k < 3) ? 1'b0 : 1'b1;
      step();
      if (fall) nf++;
      if (hold) nh++;
      if (!level) low_seen++;
    end
    check("dip_no_fall", nf, 0);
    check("dip_no_rehold", nh, 0);
    check("dip_level_kept", low_seen, 0);
    btn = 1'b0;
    nf = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (fall) nf++;
    end
    check("release_fall_count", nf, 1);
    check("release_level", int'(level), 0);

    // Reset while arming (dcnt=3), button held through and after reset.
    btn = 1'b1;
    repeat (5) step();
    check("arm_busy", int'(busy), 1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_outputs", int'(dut_vec), 0);
    end
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      check("rst_release_rise", int'(rise), int'(j == 6));
    end
    btn = 1'b0;
    repeat (12) step();

    // Fast instance: single-sample debounce, hold disabled.
    btn_f = 1'b1; nr = 0; r_at = -1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (rise_f) begin nr++; r_at = k; end
    end
    check("fast_rise_edge", r_at, 2);
    check("fast_rise_count", nr, 1);
    check("fast_level", int'(level_f), 1);
    btn_f = 1'b0;
    repeat (6) step();

    // Random segments with occasional resets.
    for (int seg = 0; seg < 70; seg++) begin
      int len;
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        repeat (int'($urandom_range(1, 3))) step();
        rst = 1'b0;
      end
      btn = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 30))
                                         : int'($urandom_range(1, 7));
      repeat (len) step();
    end

    check("fast_never_hold", fast_holds, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
